// File: rtl/custom_clk_div_if.sv
`default_nettype none
//============================================================================
// custom_clk_div_if : control/pulse bundle for the programmable rate generator
// Rev 1.0
//============================================================================
interface custom_clk_div_if #(
   parameter int WIDTH = 26
);
   logic             enable;
   logic [WIDTH-1:0] load_value;
   logic             clk_out;

   modport master (
      output enable,
      output load_value,
      input  clk_out
   );

   modport slave (
      input  enable,
      input  load_value,
      output clk_out
   );
endinterface
`default_nettype wire

// File: rtl/custom_clk_div.sv
`default_nettype none
//============================================================================
// custom_clk_div : emits a registered one-cycle pulse every load_value enabled
//                  cycles of sixtyhz_clk
// Rev 1.0
//============================================================================
module custom_clk_div #(
   parameter int WIDTH = 26
) (
   input  wire              sixtyhz_clk,
   input  wire              resetn,
   custom_clk_div_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cnt;
   logic             r_clk_out;
   logic             w_small_load;
   logic             w_end_of_period;
   logic [WIDTH-1:0] w_last_cnt;

   // load_value-1 only matters when load_value>=2; 0 and 1 pulse every cycle.
   assign w_small_load    = (bus.load_value <= c_one);
   assign w_last_cnt      = bus.load_value - c_one;
   assign w_end_of_period = w_small_load || (r_cnt >= w_last_cnt);

   always_ff @(posedge sixtyhz_clk) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
      end else if (bus.enable) begin
         if (w_end_of_period) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b1;
         end else begin
            r_cnt     <= r_cnt + c_one;
            r_clk_out <= 1'b0;
         end
      end else begin
         r_clk_out <= 1'b0;
      end
   end

   assign bus.clk_out = r_clk_out;

endmodule
`default_nettype wire

// File: tb/tb_custom_clk_div.sv
`default_nettype none
//============================================================================
// tb_custom_clk_div : directed self-checking bench for custom_clk_div
// Rev 1.0
//============================================================================
module tb_custom_clk_div;

   localparam int c_width = 26;

   logic sixtyhz_clk;
   logic resetn;
   int   n_checks;
   int   n_pass;
   logic exp_v;

   custom_clk_div_if #(.WIDTH(c_width)) bus ();

   custom_clk_div #(.WIDTH(c_width)) dut (
      .sixtyhz_clk (sixtyhz_clk),
      .resetn      (resetn),
      .bus         (bus)
   );

   initial sixtyhz_clk = 1'b0;
   always #5 sixtyhz_clk = ~sixtyhz_clk;

   task automatic tick();
      @(posedge sixtyhz_clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn         = 1'b0;
      bus.enable     = 1'b1;
      bus.load_value = 26'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.clk_out !== 1'b0)
            $display("FAIL reset cyc%0d: clk_out=%b expected 0", i, bus.clk_out);
         else
            n_pass++;
      end
      resetn = 1'b1;
   endtask

   task automatic test_period();
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_v = ((i % 5) == 0);
         n_checks++;
         if (bus.clk_out !== exp_v)
            $display("FAIL period cyc%0d: clk_out=%b expected %b", i, bus.clk_out, exp_v);
         else
            n_pass++;
      end
   endtask

   task automatic test_degenerate();
      for (int l = 1; l >= 0; l--) begin
         bus.load_value = c_width'(l);
         for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.clk_out !== 1'b1)
               $display("FAIL degenerate load%0d cyc%0d: clk_out=%b expected 1", l, i, bus.clk_out);
            else
               n_pass++;
         end
      end
   endtask

   task automatic test_enable_gating();
      logic exp_seq [0:6];
      logic en_seq  [0:6];
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      en_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      bus.load_value = 26'd4;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         bus.enable = en_seq[i];
         tick();
         n_checks++;
         if (bus.clk_out !== exp_seq[i])
            $display("FAIL enable cyc%0d: clk_out=%b expected %b", i, bus.clk_out, exp_seq[i]);
         else
            n_pass++;
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_live_change();
      bus.load_value = 26'd10;
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_checks++;
         if (bus.clk_out !== 1'b0)
            $display("FAIL live pre cyc%0d: clk_out=%b expected 0", i, bus.clk_out);
         else
            n_pass++;
      end
      // counter is now 7, already past the new terminal count of 2
      bus.load_value = 26'd3;
      for (int i = 0; i <= 6; i++) begin
         tick();
         exp_v = ((i % 3) == 0);
         n_checks++;
         if (bus.clk_out !== exp_v)
            $display("FAIL live post cyc%0d: clk_out=%b expected %b", i, bus.clk_out, exp_v);
         else
            n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      bus.load_value = 26'd6;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      resetn = 1'b0;
      tick();
      n_checks++;
      if (bus.clk_out !== 1'b0)
         $display("FAIL reset_mid during: clk_out=%b expected 0", bus.clk_out);
      else
         n_pass++;
      resetn = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_v = (i == 6);
         n_checks++;
         if (bus.clk_out !== exp_v)
            $display("FAIL reset_mid after cyc%0d: clk_out=%b expected %b", i, bus.clk_out, exp_v);
         else
            n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      bus.load_value = 26'd2;
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_v = ((i % 2) == 0);
         n_checks++;
         if (bus.clk_out !== exp_v)
            $display("FAIL div2 cyc%0d: clk_out=%b expected %b", i, bus.clk_out, exp_v);
         else
            n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_period();
      test_degenerate();
      test_enable_gating();
      test_live_change();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
